// File: rtl/audio_pkg.sv
// Shared audio types for the DAC feed path: sample type, feeder states,
// frame timing constant and the output format helper.
package audio_pkg;

  typedef logic [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } feed_state_t;

  // 24-bit DAC8550 frame plus SYNC recovery, in sclk cycles
  localparam int DAC_FRAME_CYCLES = 26;

  // Offset-binary sources get their MSB flipped into two's complement
  function automatic sample_t fmt_sample(input sample_t x, input bit twos_comp);
    return twos_comp ? x : {~x[15], x[14:0]};
  endfunction

endpackage

// File: rtl/dac_sample_feeder_if.sv
// Upstream sample handshake: producer drives valid/data, feeder returns ready.
interface dac_sample_feeder_if;
  import audio_pkg::*;

  logic    in_valid;
  sample_t in_data;
  logic    in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/sample_fifo.sv
// Single-clock FIFO. Push is ignored when full and pop is ignored when
// empty, so callers may present raw requests. Storage is not reset.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     sclk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  // no write bypass: a full FIFO refuses the push even if a pop happens too
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // sample storage, deliberately left out of reset
  always_ff @(posedge sclk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // occupancy: unchanged on simultaneous push and pop
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_feeder.sv
// Paces buffered samples into the DAC8550 driver: one endac pulse every
// PERIOD sclk cycles once PREFILL samples are queued, with the popped sample
// registered onto indata on the same edge that raises endac.
module dac_sample_feeder
  import audio_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PERIOD    = 26,
  parameter int PREFILL   = 4,
  parameter bit TWOS_COMP = 1'b1
) (
  input  logic                   sclk,
  input  logic                   rst_n,
  input  logic                   en,
  dac_sample_feeder_if.slave     up,
  output logic                   endac,
  output sample_t                indata,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(PERIOD);

  if (PERIOD < DAC_FRAME_CYCLES) begin : g_chk_period
    $error("PERIOD shorter than one DAC frame");
  end
  if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("DEPTH must be a power of two in 2..64");
  end
  if ((PREFILL < 1) || (PREFILL > DEPTH)) begin : g_chk_prefill
    $error("PREFILL must be in 1..DEPTH");
  end

  feed_state_t   state;
  feed_state_t   state_nxt;
  logic [CW-1:0] cnt;
  logic          fire;
  logic          full;
  logic          empty;
  sample_t       head;

  sample_fifo #(
    .DEPTH (DEPTH),
    .W     (16)
  ) u_fifo (
    .sclk  (sclk),
    .rst_n (rst_n),
    .push  (up.in_valid),
    .pop   (fire),
    .wdata (up.in_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // ready depends on occupancy only, never on in_valid
  assign up.in_ready = ~full;

  // a pulse is due on the edge after the counter sits at PERIOD-1; dropping
  // en in that cycle suppresses it
  assign fire = (state == RUN) && en && (cnt == CW'(PERIOD - 1));

  // state register
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: en low always returns to IDLE; FIFO contents survive
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = PRIME;
      PRIME: begin
        if (!en)                        state_nxt = IDLE;
        else if (level >= LW'(PREFILL)) state_nxt = RUN;
      end
      RUN:     if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // period counter: runs only in RUN with en high, otherwise held at 0
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state == RUN) && en) begin
      cnt <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  // frame-start pulse, underrun flag and the held output sample
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      endac    <= 1'b0;
      underrun <= 1'b0;
      indata   <= '0;
    end else begin
      endac    <= fire;
      underrun <= fire & empty;
      if (fire && !empty) indata <= fmt_sample(head, TWOS_COMP);
    end
  end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Directed bench for dac_sample_feeder: one two's-complement instance for
// pacing/FIFO/reset behaviour and one offset-binary instance for formatting.
module tb_dac_sample_feeder;
  import audio_pkg::*;

  logic    sclk = 1'b0;
  logic    rst_n;
  logic    en_a, en_b;
  logic    endac_a, endac_b;
  logic    underrun_a, underrun_b;
  sample_t indata_a, indata_b;
  logic [3:0] level_a, level_b;

  int nvec = 0;
  int nerr = 0;

  always #5 sclk = ~sclk;

  dac_sample_feeder_if ia();
  dac_sample_feeder_if ib();

  dac_sample_feeder #(.DEPTH(8), .PERIOD(26), .PREFILL(4), .TWOS_COMP(1'b1)) dut_a (
    .sclk(sclk), .rst_n(rst_n), .en(en_a), .up(ia),
    .endac(endac_a), .indata(indata_a), .underrun(underrun_a), .level(level_a)
  );

  dac_sample_feeder #(.DEPTH(8), .PERIOD(26), .PREFILL(4), .TWOS_COMP(1'b0)) dut_b (
    .sclk(sclk), .rst_n(rst_n), .en(en_b), .up(ib),
    .endac(endac_b), .indata(indata_b), .underrun(underrun_b), .level(level_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic push_a(input sample_t d);
    ia.in_valid = 1'b1;
    ia.in_data  = d;
    tick;
    ia.in_valid = 1'b0;
  endtask

  task automatic push_b(input sample_t d);
    ib.in_valid = 1'b1;
    ib.in_data  = d;
    tick;
    ib.in_valid = 1'b0;
  endtask

  // ticks until the selected endac is seen (bounded) and checks the count
  task automatic wait_pulse(input bit sel_b, input int exp, input string tag);
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (!(sel_b ? endac_b : endac_a) && n < 200);
    chk(tag, n, exp);
  endtask

  task automatic quiet_a(input int n, input string tag);
    int c;
    c = 0;
    repeat (n) begin
      tick;
      if (endac_a) c++;
    end
    chk(tag, c, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    en_a = 1'b0; en_b = 1'b0;
    ia.in_valid = 1'b0; ia.in_data = '0;
    ib.in_valid = 1'b0; ib.in_data = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_endac",    32'(endac_a),    32'd0);
    chk("rst_indata",   32'(indata_a),   32'h0);
    chk("rst_underrun", 32'(underrun_a), 32'd0);
    chk("rst_level",    32'(level_a),    32'd0);
    chk("rst_ready",    32'(ia.in_ready), 32'd1);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // fill to full, then keep offering a sample that must be refused
    ia.in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      ia.in_data = sample_t'(i);
      tick;
    end
    ia.in_data = 16'hDEAD;
    chk("full_ready", 32'(ia.in_ready), 32'd0);
    chk("full_level", 32'(level_a),     32'd8);

    // IDLE->PRIME->RUN takes two edges, then PERIOD to the first pulse
    en_a = 1'b1;
    wait_pulse(1'b0, 28, "first_pulse_time");
    ia.in_valid = 1'b0;
    chk("pulse1_indata", 32'(indata_a),    32'h0001);
    chk("pop_full_lvl",  32'(level_a),     32'd7);
    chk("pop_full_rdy",  32'(ia.in_ready), 32'd1);
    tick;
    chk("pulse_width",   32'(endac_a),  32'd0);
    chk("indata_hold",   32'(indata_a), 32'h0001);

    wait_pulse(1'b0, 25, "pulse2_time");
    chk("pulse2_indata", 32'(indata_a), 32'h0002);
    for (int k = 3; k <= 8; k++) begin
      wait_pulse(1'b0, 26, $sformatf("pulse%0d_time", k));
      chk($sformatf("pulse%0d_indata", k), 32'(indata_a), 32'(k));
      chk($sformatf("pulse%0d_level", k),  32'(level_a),  32'(8 - k));
    end

    // empty FIFO: pulse still fires, underrun flags it, indata holds
    wait_pulse(1'b0, 26, "under_time");
    chk("under_flag",   32'(underrun_a), 32'd1);
    chk("under_indata", 32'(indata_a),   32'h0008);
    chk("under_level",  32'(level_a),    32'd0);
    tick;
    chk("under_width",  32'(underrun_a), 32'd0);

    // reset mid-frame with 5 samples queued
    for (int i = 0; i < 5; i++) push_a(sample_t'(16'h0021 + i));
    chk("mid_level", 32'(level_a), 32'd5);
    rst_n = 1'b0;
    en_a  = 1'b0;
    #1;
    chk("mrst_endac",    32'(endac_a),     32'd0);
    chk("mrst_indata",   32'(indata_a),    32'h0);
    chk("mrst_underrun", 32'(underrun_a),  32'd0);
    chk("mrst_level",    32'(level_a),     32'd0);
    chk("mrst_ready",    32'(ia.in_ready), 32'd1);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_level", 32'(level_a), 32'd0);

    // below PREFILL nothing paces; the 4th sample starts RUN
    en_a = 1'b1;
    push_a(16'h0031); push_a(16'h0032); push_a(16'h0033);
    quiet_a(40, "no_pulse_below_prefill");
    push_a(16'h0034);
    push_a(16'h0035);
    wait_pulse(1'b0, 26, "prefill_start_time");
    chk("prefill_indata", 32'(indata_a), 32'h0031);
    chk("prefill_level",  32'(level_a),  32'd4);

    // drop en in the cycle the pulse is due: suppressed, FIFO untouched
    repeat (25) tick;
    en_a = 1'b0;
    quiet_a(40, "en_drop_no_pulse");
    chk("en_drop_level",  32'(level_a),  32'd4);
    chk("en_drop_indata", 32'(indata_a), 32'h0031);
    en_a = 1'b1;
    wait_pulse(1'b0, 28, "reenter_time");
    chk("reenter_indata", 32'(indata_a), 32'h0032);
    chk("reenter_level",  32'(level_a),  32'd3);
    en_a = 1'b0;

    // offset-binary instance: MSB inverted on output
    push_b(16'h8000); push_b(16'h0000); push_b(16'h0001); push_b(16'h0002);
    en_b = 1'b1;
    wait_pulse(1'b1, 28, "ob_first_time");
    chk("ob_indata1", 32'(indata_b), 32'h0000);
    wait_pulse(1'b1, 26, "ob_second_time");
    chk("ob_indata2", 32'(indata_b), 32'h8000);
    wait_pulse(1'b1, 26, "ob_third_time");
    chk("ob_indata3", 32'(indata_b), 32'h8001);
    en_b = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
